// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive frame controller. Drives an external bit-period
//             down-counter, synchronises rx, validates the start bit, samples
//             data at mid-bit, checks stop (and optional parity) and delivers
//             bytes through a one-entry valid/ready holding register.
//  Options  : UART_RX_PARITY_EN - adds a parity bit (sense set by PARITY_ODD)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    input  logic [$clog2(CLKS_PER_BIT)-1:0] cnt_i,
    input  logic                            cnt_done_i,
    output logic                            cnt_en_o,
    output logic                            cnt_soft_rst_o,
    output logic [DATA_BITS-1:0]            rx_data_o,
    output logic                            rx_valid_o,
    input  logic                            rx_ready_i,
    output logic                            frame_err_o,
    output logic                            par_err_o,
    output logic                            overrun_o
);

    localparam int                  c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int                  c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0]  c_MID   = c_CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_par_err;
    logic                   r_overrun;
    logic                   w_cnt_en;
    logic                   w_cnt_soft_rst;
    logic                   w_mid;
    logic                   w_stop_eval;
    logic                   w_stop_bad;
    logic                   w_par_bad;
    logic                   w_good;

    // Mid-bit sample strobe; the counter only runs outside IDLE.
    assign w_mid       = (r_state != S_IDLE) && (cnt_i == c_MID);
    assign w_stop_eval = (r_state == S_STOP) && w_mid;
    assign w_stop_bad  = ~r_rx_s;

`ifdef UART_RX_PARITY_EN
    localparam logic c_PAR_ODD = (PARITY_ODD != 0);
    logic r_par_bit;

    // Total ones over data plus parity must match the configured sense.
    assign w_par_bad = ((^r_shift) ^ r_par_bit) != c_PAR_ODD;

    // Capture the received parity bit at its mid-bit sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bit <= 1'b0;
        end else if ((r_state == S_PARITY) && w_mid) begin
            r_par_bit <= r_rx_s;
        end
    end
`else
    // Parity sense has no meaning without a parity bit.
    logic w_unused_par;
    assign w_unused_par = (PARITY_ODD != 0);
    assign w_par_bad    = 1'b0;
`endif

    assign w_good = ~w_stop_bad & ~w_par_bad;

    // Two-flop synchroniser on the asynchronous serial line, idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and counter control decoded from state.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_en       = 1'b1;
        w_cnt_soft_rst = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_en       = 1'b0;
                w_cnt_soft_rst = 1'b1;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // The mid sample precedes the bit boundary, so a false start
                // always leaves before cnt_done_i can arrive.
                if (w_mid && r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else if (cnt_done_i) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_done_i && (r_bit_idx == c_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_done_i) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so the next start edge is caught early.
                if (w_mid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (cnt_done_i) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if ((r_state == S_DATA) && w_mid) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // Error pulses, one cycle after the stop-bit evaluation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_eval & w_stop_bad;
            r_par_err   <= w_stop_eval & ~w_stop_bad & w_par_bad;
        end
    end

    // One-entry holding register; a full, unaccepted entry drops the new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_stop_eval && w_good) begin
                if (!r_valid || rx_ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cnt_en_o       = w_cnt_en;
    assign cnt_soft_rst_o = w_cnt_soft_rst;
    assign rx_data_o      = r_data;
    assign rx_valid_o     = r_valid;
    assign frame_err_o    = r_frame_err;
    assign par_err_o      = r_par_err;
    assign overrun_o      = r_overrun;

endmodule
`default_nettype wire
